instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 155 +++++++++++++++
 tb/tb_instr_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Encodes R/LOAD/STORE/BRANCH requests into 32-bit instruction
//             words plus expected control bits, buffered in an output FIFO.
//             Optional immediate range check enabled by ENC_RANGE_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_class,
   input  logic [4:0]         req_rd,
   input  logic [4:0]         req_rs1,
   input  logic [4:0]         req_rs2,
   input  logic [2:0]         req_funct3,
   input  logic [6:0]         req_funct7,
   input  logic [12:0]        req_imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_instr,
   output logic [7:0]         out_ctrl,
   output logic [COUNT_W-1:0] instr_count,
   output logic               err
);

   localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);

   localparam logic [1:0]    CLS_R      = 2'b00;
   localparam logic [1:0]    CLS_LOAD   = 2'b01;
   localparam logic [1:0]    CLS_STORE  = 2'b10;

   localparam logic [6:0]    OP_R      = 7'b0110011;
   localparam logic [6:0]    OP_LOAD   = 7'b0000011;
   localparam logic [6:0]    OP_STORE  = 7'b0100011;
   localparam logic [6:0]    OP_BRANCH = 7'b1100011;

   localparam logic [7:0]    CTRL_R      = 8'b0010_0010;
   localparam logic [7:0]    CTRL_LOAD   = 8'b1111_0000;
   localparam logic [7:0]    CTRL_STORE  = 8'b1000_1000;
   localparam logic [7:0]    CTRL_BRANCH = 8'b0000_0101;

   logic [31:0]        instr_mem_q [FIFO_DEPTH];
   logic [7:0]         ctrl_mem_q  [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [AW:0]        occ_q, occ_d;
   logic [COUNT_W-1:0] count_q;

   logic [31:0]        enc_instr;
   logic [7:0]         enc_ctrl;
   logic               accept, push, pop, reject;

   always_comb begin
      enc_instr = '0;
      enc_ctrl  = '0;
      case (req_class)
         CLS_R: begin
            enc_instr = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
            enc_ctrl  = CTRL_R;
         end
         CLS_LOAD: begin
            enc_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
            enc_ctrl  = CTRL_LOAD;
         end
         CLS_STORE: begin
            enc_instr = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:0], OP_STORE};
            enc_ctrl  = CTRL_STORE;
         end
         default: begin
            enc_instr = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:1], req_imm[11], OP_BRANCH};
            enc_ctrl  = CTRL_BRANCH;
         end
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   logic err_q;

   // LOAD/STORE need a sign-extendable 12-bit value; branch offsets must be even
   always_comb begin
      reject = 1'b0;
      case (req_class)
         CLS_LOAD, CLS_STORE: reject = (req_imm[12] != req_imm[11]);
         CLS_R:               reject = 1'b0;
         default:             reject = req_imm[0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= accept && reject;
   end

   assign err = err_q;
`else
   logic unused_imm_lsb;

   assign reject         = 1'b0;
   assign err            = 1'b0;
   assign unused_imm_lsb = req_imm[0];
`endif

   assign req_ready = (occ_q != DEPTH_L);
   assign out_valid = (occ_q != '0);
   assign accept    = req_valid && req_ready;
   assign push      = accept && !reject;
   assign pop       = out_valid && out_ready;

   always_comb begin
      occ_d = occ_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         count_q  <= '0;
      end else begin
         occ_q <= occ_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: contents are masked whenever the buffer is empty
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= enc_instr;
         ctrl_mem_q[wr_ptr_q]  <= enc_ctrl;
      end
   end

   assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign out_ctrl    = out_valid ? ctrl_mem_q[rd_ptr_q]  : '0;
   assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking bench for instr_encoder against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

   localparam int FIFO_DEPTH = 4;
   localparam int COUNT_W    = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [1:0]         req_class = '0;
   logic [4:0]         req_rd = '0, req_rs1 = '0, req_rs2 = '0;
   logic [2:0]         req_funct3 = '0;
   logic [6:0]         req_funct7 = '0;
   logic [12:0]        req_imm = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [31:0]        out_instr;
   logic [7:0]         out_ctrl;
   logic [COUNT_W-1:0] instr_count;
   logic               err;

   instr_encoder #(.FIFO_DEPTH(FIFO_DEPTH), .COUNT_W(COUNT_W)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_ctrl(out_ctrl),
      .instr_count(instr_count), .err(err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [39:0] mdl_q[$];
   int unsigned mdl_count = 0;
   logic        mdl_err   = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned model_word(input int unsigned cls, rd, rs1, rs2, f3, f7, imm);
      int unsigned w;
      case (cls)
         0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
         1: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
         2: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                | ((imm & 32'h1F) << 7) | 32'h23;
         default: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 11) & 1) << 7) | 32'h63;
      endcase
      return w;
   endfunction

   function automatic logic [7:0] model_ctrl(input int unsigned cls);
      case (cls)
         0:       return 8'h22;
         1:       return 8'hF0;
         2:       return 8'h88;
         default: return 8'h05;
      endcase
   endfunction

   function automatic bit model_bad(input int unsigned cls, input int unsigned imm);
`ifdef ENC_RANGE_CHECK_EN
      if (cls == 1 || cls == 2) return ((imm >> 12) & 1) != ((imm >> 11) & 1);
      if (cls == 3)             return (imm & 1) != 0;
`endif
      return 1'b0;
   endfunction

   task automatic clear_model();
      mdl_q.delete();
      mdl_count = 0;
      mdl_err   = 1'b0;
   endtask

   // Check all outputs against the model, then advance one clock edge
   task automatic cycle();
      bit          m_ready, m_valid, do_push, do_pop, bad;
      logic [39:0] head, entry;
      m_ready = (mdl_q.size() < FIFO_DEPTH);
      m_valid = (mdl_q.size() != 0);
      head    = m_valid ? mdl_q[0] : 40'h0;
      check_val("req_ready",   {31'h0, req_ready}, {31'h0, m_ready});
      check_val("out_valid",   {31'h0, out_valid}, {31'h0, m_valid});
      check_val("out_instr",   out_instr, head[39:8]);
      check_val("out_ctrl",    {24'h0, out_ctrl}, {24'h0, head[7:0]});
      check_val("instr_count", {16'h0, instr_count}, mdl_count & ((1 << COUNT_W) - 1));
      check_val("err",         {31'h0, err}, {31'h0, mdl_err});
      bad     = model_bad(req_class, req_imm);
      do_push = req_valid && m_ready && !bad;
      do_pop  = m_valid && out_ready;
      entry   = {model_word(req_class, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm),
                 model_ctrl(req_class)};
      @(posedge clk);
      #1;
      mdl_err = req_valid && m_ready && bad;
      if (do_pop) begin
         void'(mdl_q.pop_front());
         mdl_count++;
      end
      if (do_push) mdl_q.push_back(entry);
   endtask

   task automatic set_req(input logic v, input logic [1:0] cls, input logic [4:0] rd, rs1, rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [12:0] imm);
      req_valid = v; req_class = cls; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
      req_funct3 = f3; req_funct7 = f7; req_imm = imm;
   endtask

   // One isolated request into an empty buffer, checked against a literal word
   task automatic send_one(input string tag, input logic [1:0] cls, input logic [4:0] rd, rs1, rs2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [12:0] imm,
                           input logic [31:0] exp_w, input logic [7:0] exp_c);
      int unsigned cnt0;
      cnt0 = mdl_count;
      out_ready = 1'b1;
      set_req(1'b1, cls, rd, rs1, rs2, f3, f7, imm);
      cycle();
      req_valid = 1'b0;
      check_val({tag, "_word"}, out_instr, exp_w);
      check_val({tag, "_ctrl"}, {24'h0, out_ctrl}, {24'h0, exp_c});
      cycle();
      check_val({tag, "_count"}, {16'h0, instr_count}, cnt0 + 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid", {31'h0, out_valid}, 32'h0);
      check_val("rst_count", {16'h0, instr_count}, 32'h0);
      rst = 1'b0;
      clear_model();
      cycle();

      send_one("r_type", 2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0ABC, 32'h002081B3, 8'h22);
      send_one("load",   2'b01, 5'd5, 5'd2, 5'd9, 3'd2, 7'h55, 13'd8,  32'h00812283, 8'hF0);
      send_one("store",  2'b10, 5'd7, 5'd2, 5'd6, 3'd2, 7'h2A, 13'd12, 32'h00612623, 8'h88);
      send_one("branch", 2'b11, 5'd9, 5'd1, 5'd2, 3'd0, 7'h7F, 13'h1FFC, 32'hFE208EE3, 8'h05);

      // Backpressure: five back-to-back requests, only four fit
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_req(1'b1, 2'b00, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
         cycle();
      end
      req_valid = 1'b0;
      check_val("bp_full", {31'h0, req_ready}, 32'h0);
      out_ready = 1'b1;
      cycle();
      check_val("bp_release", {31'h0, req_ready}, 32'h1);
      repeat (5) cycle();

      // Range check on an out-of-range LOAD immediate
      begin
         int unsigned cnt0;
         cnt0 = mdl_count;
         set_req(1'b1, 2'b01, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0800);
         cycle();
         req_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
         check_val("range_err",   {31'h0, err}, 32'h1);
         check_val("range_valid", {31'h0, out_valid}, 32'h0);
         cycle();
         check_val("range_err_clr", {31'h0, err}, 32'h0);
         check_val("range_count", {16'h0, instr_count}, cnt0);
`else
         check_val("range_word", out_instr, 32'h80000003);
         check_val("range_err",  {31'h0, err}, 32'h0);
         cycle();
         check_val("range_count", {16'h0, instr_count}, cnt0 + 1);
`endif
      end

      // Mid-operation reset with three entries buffered
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, 2'b01, 5'(i + 10), 5'd4, 5'd0, 3'd1, 7'd0, 13'(i * 4));
         cycle();
      end
      req_valid = 1'b0;
      check_val("pre_rst_valid", {31'h0, out_valid}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check_val("mid_rst_valid", {31'h0, out_valid}, 32'h0);
      check_val("mid_rst_count", {16'h0, instr_count}, 32'h0);
      clear_model();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         set_req(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), 13'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      req_valid = 1'b0;
      out_ready = 1'b1;
      repeat (FIFO_DEPTH + 2) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
